rr_channel_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares one downstream channel between N_REQ requesters.
- Drives the select and one-hot grant that steer the mux/demux steering network onto the shared channel.
- Holds each grant for a burst, bounded by MAX_BURST beats, then rotates priority.
- Sits between requester blocks and any single shared resource, e.g. a register write port or a serial link.

---
 rtl/rr_channel_arbiter_if.sv | 31 +++
 rtl/rr_channel_arbiter.sv | 114 +++++++++++
 tb/tb_rr_channel_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_channel_arbiter_if.sv
// Channel bundle between requesters and rr_channel_arbiter; the lock vector is present only under ARB_LOCK_EN.
// master = requester/channel side, slave = arbiter side.
interface rr_channel_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic                    out_ready;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0]        lock;
`endif
  logic [N_REQ-1:0]        grant;
  logic [SEL_W-1:0]        sel;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    busy;

`ifdef ARB_LOCK_EN
  modport master (output req, in_data, out_ready, lock,
                  input  grant, sel, out_valid, out_data, busy);
  modport slave  (input  req, in_data, out_ready, lock,
                  output grant, sel, out_valid, out_data, busy);
`else
  modport master (output req, in_data, out_ready,
                  input  grant, sel, out_valid, out_data, busy);
  modport slave  (input  req, in_data, out_ready,
                  output grant, sel, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/rr_channel_arbiter.sv
// Round-robin burst arbiter for one shared channel; grant 1 cycle after req, 1 dead cycle after release.
// out_ready only paces beat counting (MAX_BURST beats per grant); ARB_LOCK_EN lets a locked owner exceed it.
module rr_channel_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SEL_W     = 2,
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_channel_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] LAST_REQ  = SEL_W'(N_REQ - 1);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  cand, winner;
  logic              found;
  logic              owner_req, owner_lock;
  logic [DATA_W-1:0] owner_data;
  logic              out_valid, beat, burst_done;

  // Scan upward from the requester after the last owner, wrapping at N_REQ.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'((int'(last_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_q == SEL_W'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.in_data[i*DATA_W +: DATA_W];
`ifdef ARB_LOCK_EN
        owner_lock = bus.lock[i];
`endif
      end
    end
  end

  assign out_valid  = (state_q == BUSY) && owner_req;
  assign beat       = out_valid && bus.out_ready;
  assign burst_done = beat && (cnt_q == LAST_BEAT) && !owner_lock;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = BUSY;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          sel_d           = winner;
          cnt_d           = '0;
        end
      end
      BUSY: begin
        if (!owner_req || burst_done) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          last_d  = sel_q;
        end else if (beat && cnt_q != LAST_BEAT) begin
          // Holding at LAST_BEAT only matters for a locked owner.
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= LAST_REQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid || (state_q == BUSY) ? owner_data : '0;
endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Randomized and directed bench for rr_channel_arbiter against an owner/beat-count reference model.
module tb_rr_channel_arbiter;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int DW  = 4;
  localparam int MB  = 8;
  localparam int DWT = N * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_channel_arbiter_if #(.N_REQ(N), .SEL_W(SW), .DATA_W(DW)) bus ();

  rr_channel_arbiter #(.N_REQ(N), .SEL_W(SW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner index (-1 when nobody holds the channel), beats served, previous owner.
  int m_owner, m_last, m_sel, m_beats;
  logic          e_valid, e_busy;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_grant;
  logic [SW-1:0] e_sel;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_sel = 0; m_beats = 0;
    e_grant = '0; e_sel = '0; e_busy = 1'b0; e_valid = 1'b0; e_data = '0;
  endtask

  task automatic pre();
    #2;
    e_valid = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      e_valid = bus.req[m_owner];
      e_data  = DW'(bus.in_data >> (m_owner * DW));
    end
  endtask

  task automatic post();
    logic [N-1:0] r;
    logic lk;
    int idx;
    r  = bus.req;
    lk = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx; m_sel = idx; m_beats = 0;
        end
      end
    end else begin
`ifdef ARB_LOCK_EN
      lk = bus.lock[m_owner];
`endif
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_beats = 0;
      end else if (bus.out_ready) begin
        m_beats++;
        if (m_beats >= MB && !lk) begin
          m_last = m_owner; m_owner = -1; m_beats = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_sel  = SW'(m_sel);
    e_busy = (m_owner >= 0);
  endtask

  task automatic drain();
    bus.req = '0;
    repeat (2) begin pre(); post(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req = '0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.sel !== '0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state got grant=%b busy=%b sel=%0d valid=%b want all zero",
               bus.grant, bus.busy, bus.sel, bus.out_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      pre();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_errors++; $display("FAIL idle_valid got %b want 0", bus.out_valid);
      end
      post();
      n_checks++;
      if (bus.grant !== '0 || bus.busy !== 1'b0) begin
        n_errors++; $display("FAIL idle_grant got grant=%b busy=%b want 0/0", bus.grant, bus.busy);
      end
    end
    bus.req = 4'b0001; bus.out_ready = 1'b1;
    pre(); post();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL pre_abort got grant=%b busy=%b want 0001/1", bus.grant, bus.busy);
    end
    #2 rst_n = 1'b0;
    bus.req = '0;
    #1;
    n_checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_abort got grant=%b busy=%b valid=%b want 0/0/0", bus.grant, bus.busy, bus.out_valid);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq[$];
    logic [N-1:0] prev;
    prev = '0;
    bus.req = 4'b0101; bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.in_data = DWT'($urandom);
      pre();
      n_checks++;
      if (bus.out_valid !== e_valid || bus.out_data !== e_data) begin
        n_errors++;
        $display("FAIL rot_out c=%0d got %b/%h want %b/%h", c, bus.out_valid, bus.out_data, e_valid, e_data);
      end
      post();
      n_checks++;
      if (bus.grant !== e_grant || bus.sel !== e_sel || bus.busy !== e_busy) begin
        n_errors++;
        $display("FAIL rot_grant c=%0d got %b/%0d/%b want %b/%0d/%b", c, bus.grant, bus.sel, bus.busy,
                 e_grant, e_sel, e_busy);
      end
      if (prev == '0 && bus.grant != '0) seq.push_back(bus.grant);
      prev = bus.grant;
    end
    n_checks++;
    if (seq.size() < 3 || seq[0] !== 4'b0001 || seq[1] !== 4'b0100 || seq[2] !== 4'b0001) begin
      n_errors++;
      $display("FAIL rot_order got %0d grants first=%b want 0001,0100,0001", seq.size(),
               seq.size() > 0 ? seq[0] : 4'b0000);
    end
    drain();
  endtask

  task automatic test_ready_toggle();
    int busy_cycles;
    busy_cycles = 0;
    bus.req = 4'b0010;
    for (int k = 0; k <= 16; k++) begin
      bus.out_ready = (k % 2 == 0);
      bus.in_data = DWT'($urandom);
      pre();
      n_checks++;
      if (bus.out_valid !== e_valid || bus.out_data !== e_data) begin
        n_errors++;
        $display("FAIL tog_out k=%0d got %b/%h want %b/%h", k, bus.out_valid, bus.out_data, e_valid, e_data);
      end
      post();
      if (bus.busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 16 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL tog_burst got busy_cycles=%0d busy=%b want 16/0", busy_cycles, bus.busy);
    end
    drain();
  endtask

  task automatic test_owner_drop();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req = (c == 0) ? 4'b1000 : (c < 4) ? 4'b1010 : 4'b0010;
      pre(); post();
      n_checks++;
      if (bus.grant !== e_grant || bus.busy !== e_busy) begin
        n_errors++;
        $display("FAIL drop_grant c=%0d got %b/%b want %b/%b", c, bus.grant, bus.busy, e_grant, e_busy);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.grant !== 4'b0000) begin
          n_errors++; $display("FAIL drop_dead got %b want 0000", bus.grant);
        end
      end
    end
    n_checks++;
    if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
      n_errors++; $display("FAIL drop_next got %b sel=%0d want 0010 sel=1", bus.grant, bus.sel);
    end
    drain();
  endtask

  task automatic test_lock();
    logic [N-1:0] want10;
`ifdef ARB_LOCK_EN
    bus.lock = 4'b0001;
    want10 = 4'b0001;
`else
    want10 = 4'b0010;
`endif
    bus.req = 4'b0011; bus.out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      pre(); post();
      n_checks++;
      if (bus.grant !== e_grant) begin
        n_errors++; $display("FAIL lock_grant c=%0d got %b want %b", c, bus.grant, e_grant);
      end
      if (c == 9) begin
        n_checks++;
        if (bus.grant !== want10) begin
          n_errors++; $display("FAIL lock_hold got %b want %b", bus.grant, want10);
        end
      end
    end
    bus.req = 4'b0010;
    pre(); post();
    pre(); post();
    n_checks++;
    if (bus.grant !== 4'b0010) begin
      n_errors++; $display("FAIL lock_release got %b want 0010", bus.grant);
    end
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
`ifdef ARB_LOCK_EN
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) bus.lock[i] = ~bus.lock[i];
`endif
      bus.in_data   = DWT'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      pre();
      n_checks++;
      if (bus.out_valid !== e_valid || bus.out_data !== e_data) begin
        n_errors++;
        $display("FAIL rnd_out c=%0d got %b/%h want %b/%h", c, bus.out_valid, bus.out_data, e_valid, e_data);
      end
      post();
      n_checks++;
      if (bus.grant !== e_grant || bus.sel !== e_sel || bus.busy !== e_busy || $countones(bus.grant) > 1) begin
        n_errors++;
        $display("FAIL rnd_grant c=%0d got %b/%0d/%b want %b/%0d/%b", c, bus.grant, bus.sel, bus.busy,
                 e_grant, e_sel, e_busy);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_ready_toggle();
    test_owner_drop();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
